// File: rtl/mem_lsu.sv
// mem_lsu: request/grant/response load-store unit between exe_mem and mem_wb.
// Sub-word stores use byte enables; misaligned and bus faults become exceptions.
module mem_lsu #(
  parameter int BUS_WIDTH   = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int RDATA_WIDTH = 32,
  parameter int TIMEOUT     = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  input  logic [4:0]             reg_waddr_i,
  input  logic                   reg_we_i,
  input  logic [RDATA_WIDTH-1:0] reg_wdata_i,
  input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
  input  logic [RDATA_WIDTH-1:0] mem_data_i,
  input  logic [3:0]             mem_op_i,
  output logic                   stall_o,
  output logic                   valid_o,
  output logic [4:0]             reg_waddr_o,
  output logic                   reg_we_o,
  output logic [RDATA_WIDTH-1:0] reg_wdata_o,
  output logic                   exc_valid_o,
  output logic [3:0]             exc_cause_o,
  output logic                   ram_req_o,
  output logic                   ram_we_o,
  output logic [BUS_WIDTH/8-1:0] ram_be_o,
  output logic [ADDR_WIDTH-1:0]  ram_addr_o,
  output logic [BUS_WIDTH-1:0]   ram_data_o,
  input  logic                   ram_gnt_i,
  input  logic                   ram_rvalid_i,
  input  logic [BUS_WIDTH-1:0]   ram_rdata_i,
  input  logic                   ram_err_i
);

  localparam int NL  = BUS_WIDTH / 8;
  localparam int LSB = $clog2(NL);
  localparam logic [ADDR_WIDTH-1:0] AMASK = ~ADDR_WIDTH'(NL - 1);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                 state_q;
  logic [7:0]             cnt_q;
  logic [2:0]             sz_q;
  logic                   sgn_q;
  logic                   st_q;
  logic [LSB-1:0]         lane_q;
  logic [4:0]             waddr_q;
  logic                   we_q;
  logic [RDATA_WIDTH-1:0] wdata_q;

  logic                   valid_q;
  logic [4:0]             reg_waddr_q;
  logic                   reg_we_q;
  logic [RDATA_WIDTH-1:0] reg_wdata_q;
  logic                   exc_valid_q;
  logic [3:0]             exc_cause_q;
  logic                   ram_req_q;
  logic                   ram_we_q;
  logic [NL-1:0]          ram_be_q;
  logic [ADDR_WIDTH-1:0]  ram_addr_q;
  logic [BUS_WIDTH-1:0]   ram_data_q;

  logic                   ld_d;
  logic                   st_d;
  logic                   sgn_d;
  logic [2:0]             sz_d;
  logic                   misal_d;
  logic                   go_d;
  logic                   resp_d;
  logic                   tmo_d;
  logic [LSB-1:0]         lane_d;
  logic [NL-1:0]          be_d;
  logic [BUS_WIDTH-1:0]   data_d;
  logic [BUS_WIDTH-1:0]   sh_d;
  logic [RDATA_WIDTH-1:0] res_d;
  logic [3:0]             fault_d;

  always_comb begin
    ld_d  = 1'b0;
    st_d  = 1'b0;
    sgn_d = 1'b0;
    sz_d  = 3'd0;
    unique case (mem_op_i)
      OP_LB:  begin ld_d = 1'b1; sgn_d = 1'b1; sz_d = 3'd1; end
      OP_LH:  begin ld_d = 1'b1; sgn_d = 1'b1; sz_d = 3'd2; end
      OP_LW:  begin ld_d = 1'b1; sz_d = 3'd4; end
      OP_LBU: begin ld_d = 1'b1; sz_d = 3'd1; end
      OP_LHU: begin ld_d = 1'b1; sz_d = 3'd2; end
      OP_SB:  begin st_d = 1'b1; sz_d = 3'd1; end
      OP_SH:  begin st_d = 1'b1; sz_d = 3'd2; end
      OP_SW:  begin st_d = 1'b1; sz_d = 3'd4; end
      default: ;
    endcase
  end

  assign lane_d  = mem_addr_i[LSB-1:0];
  assign misal_d = ((sz_d == 3'd2) & mem_addr_i[0]) |
                   ((sz_d == 3'd4) & (|mem_addr_i[1:0]));
  assign go_d    = (state_q == IDLE) & valid_i & (ld_d | st_d) & ~misal_d;

  // Store data is replicated so every candidate lane carries it.
  always_comb begin
    be_d   = '0;
    data_d = {(BUS_WIDTH/32){mem_data_i[31:0]}};
    unique case (sz_d)
      3'd1: begin
        be_d   = NL'(1);
        data_d = {NL{mem_data_i[7:0]}};
      end
      3'd2: begin
        be_d   = NL'(3);
        data_d = {(NL/2){mem_data_i[15:0]}};
      end
      3'd4: be_d = NL'(15);
      default: ;
    endcase
    be_d = be_d << lane_d;
  end

  always_comb begin
    sh_d  = ram_rdata_i >> {lane_q, 3'b000};
    res_d = '0;
    unique case (sz_q)
      3'd1: begin
        res_d      = {RDATA_WIDTH{sgn_q & sh_d[7]}};
        res_d[7:0] = sh_d[7:0];
      end
      3'd2: begin
        res_d       = {RDATA_WIDTH{sgn_q & sh_d[15]}};
        res_d[15:0] = sh_d[15:0];
      end
      default: res_d[31:0] = sh_d[31:0];
    endcase
  end

  assign resp_d  = ram_rvalid_i &
                   (((state_q == REQ) & ram_gnt_i) | (state_q == WAIT));
  assign tmo_d   = (state_q != IDLE) & (cnt_q == 8'(TIMEOUT - 1)) & ~resp_d;
  assign fault_d = st_q ? 4'd7 : 4'd5;
  assign stall_o = go_d | ((state_q != IDLE) & ~resp_d & ~tmo_d);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sz_q        <= '0;
      sgn_q       <= 1'b0;
      st_q        <= 1'b0;
      lane_q      <= '0;
      waddr_q     <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      valid_q     <= 1'b0;
      reg_waddr_q <= '0;
      reg_we_q    <= 1'b0;
      reg_wdata_q <= '0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= '0;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_be_q    <= '0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
    end else begin
      valid_q     <= 1'b0;
      reg_we_q    <= 1'b0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (valid_i) begin
            if (!(ld_d | st_d)) begin
              valid_q     <= 1'b1;
              reg_we_q    <= reg_we_i;
              reg_waddr_q <= reg_waddr_i;
              reg_wdata_q <= reg_wdata_i;
            end else if (misal_d) begin
              valid_q     <= 1'b1;
              reg_waddr_q <= reg_waddr_i;
              reg_wdata_q <= reg_wdata_i;
              exc_valid_q <= 1'b1;
              exc_cause_q <= st_d ? 4'd6 : 4'd4;
            end else begin
              state_q    <= REQ;
              cnt_q      <= '0;
              sz_q       <= sz_d;
              sgn_q      <= sgn_d;
              st_q       <= st_d;
              lane_q     <= lane_d;
              waddr_q    <= reg_waddr_i;
              we_q       <= reg_we_i;
              wdata_q    <= reg_wdata_i;
              ram_req_q  <= 1'b1;
              ram_we_q   <= st_d;
              ram_be_q   <= be_d;
              ram_addr_q <= mem_addr_i & AMASK;
              ram_data_q <= data_d;
            end
          end
        end
        REQ, WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          if ((state_q == REQ) && ram_gnt_i) begin
            state_q   <= WAIT;
            ram_req_q <= 1'b0;
          end
          if (resp_d) begin
            state_q     <= IDLE;
            ram_req_q   <= 1'b0;
            valid_q     <= 1'b1;
            reg_waddr_q <= waddr_q;
            reg_we_q    <= we_q & ~ram_err_i;
            reg_wdata_q <= (st_q || ram_err_i) ? wdata_q : res_d;
            exc_valid_q <= ram_err_i;
            exc_cause_q <= ram_err_i ? fault_d : 4'd0;
          end else if (tmo_d) begin
            state_q     <= IDLE;
            ram_req_q   <= 1'b0;
            valid_q     <= 1'b1;
            reg_waddr_q <= waddr_q;
            reg_wdata_q <= wdata_q;
            exc_valid_q <= 1'b1;
            exc_cause_q <= fault_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign valid_o     = valid_q;
  assign reg_waddr_o = reg_waddr_q;
  assign reg_we_o    = reg_we_q;
  assign reg_wdata_o = reg_wdata_q;
  assign exc_valid_o = exc_valid_q;
  assign exc_cause_o = exc_cause_q;
  assign ram_req_o   = ram_req_q;
  assign ram_we_o    = ram_we_q;
  assign ram_be_o    = ram_be_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_data_o  = ram_data_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: random and directed loads/stores against a byte-level RAM model.
// The bench plays the RAM slave and predicts every writeback and exception.
module tb_mem_lsu;

  localparam int BW  = 64;
  localparam int AW  = 32;
  localparam int RW  = 32;
  localparam int TMO = 8;
  localparam int NL  = BW / 8;

  localparam logic [3:0] LB  = 4'd1;
  localparam logic [3:0] LH  = 4'd2;
  localparam logic [3:0] LW  = 4'd3;
  localparam logic [3:0] LBU = 4'd4;
  localparam logic [3:0] LHU = 4'd5;
  localparam logic [3:0] SB  = 4'd6;
  localparam logic [3:0] SH  = 4'd7;
  localparam logic [3:0] SW  = 4'd8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          valid_i;
  logic [4:0]    reg_waddr_i;
  logic          reg_we_i;
  logic [RW-1:0] reg_wdata_i;
  logic [AW-1:0] mem_addr_i;
  logic [RW-1:0] mem_data_i;
  logic [3:0]    mem_op_i;
  logic          stall_o;
  logic          valid_o;
  logic [4:0]    reg_waddr_o;
  logic          reg_we_o;
  logic [RW-1:0] reg_wdata_o;
  logic          exc_valid_o;
  logic [3:0]    exc_cause_o;
  logic          ram_req_o;
  logic          ram_we_o;
  logic [NL-1:0] ram_be_o;
  logic [AW-1:0] ram_addr_o;
  logic [BW-1:0] ram_data_o;
  logic          ram_gnt_i;
  logic          ram_rvalid_i;
  logic [BW-1:0] ram_rdata_i;
  logic          ram_err_i;

  always #5 clk_i = ~clk_i;

  mem_lsu #(
    .BUS_WIDTH  (BW),
    .ADDR_WIDTH (AW),
    .RDATA_WIDTH(RW),
    .TIMEOUT    (TMO)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .reg_waddr_i (reg_waddr_i),
    .reg_we_i    (reg_we_i),
    .reg_wdata_i (reg_wdata_i),
    .mem_addr_i  (mem_addr_i),
    .mem_data_i  (mem_data_i),
    .mem_op_i    (mem_op_i),
    .stall_o     (stall_o),
    .valid_o     (valid_o),
    .reg_waddr_o (reg_waddr_o),
    .reg_we_o    (reg_we_o),
    .reg_wdata_o (reg_wdata_o),
    .exc_valid_o (exc_valid_o),
    .exc_cause_o (exc_cause_o),
    .ram_req_o   (ram_req_o),
    .ram_we_o    (ram_we_o),
    .ram_be_o    (ram_be_o),
    .ram_addr_o  (ram_addr_o),
    .ram_data_o  (ram_data_o),
    .ram_gnt_i   (ram_gnt_i),
    .ram_rvalid_i(ram_rvalid_i),
    .ram_rdata_i (ram_rdata_i),
    .ram_err_i   (ram_err_i)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] mem [int unsigned];

  task automatic check(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int op_size(input logic [3:0] op);
    case (op)
      LB, LBU, SB: return 1;
      LH, LHU, SH: return 2;
      LW, SW:      return 4;
      default:     return 0;
    endcase
  endfunction

  function automatic logic [7:0] rd(input int unsigned a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, valid_o, 0);
    check({tag, "_we"}, reg_we_o, 0);
    check({tag, "_waddr"}, reg_waddr_o, 0);
    check({tag, "_wdata"}, reg_wdata_o, 0);
    check({tag, "_exc"}, {exc_valid_o, exc_cause_o}, 0);
    check({tag, "_req"}, ram_req_o, 0);
    check({tag, "_rwe"}, ram_we_o, 0);
    check({tag, "_be"}, ram_be_o, 0);
    check({tag, "_addr"}, ram_addr_o, 0);
    check({tag, "_data"}, ram_data_o, 0);
    check({tag, "_stall"}, stall_o, 0);
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] data, input int gdly,
                       input int rdly, input bit err, input bit tmo);
    int sz;
    bit st, sgn, mis, acc;
    logic [4:0] wa;
    logic rwe;
    logic [31:0] rwd, base, eres;
    logic [NL-1:0] ebe;
    logic [BW-1:0] edat, bus;
    logic [63:0] v;
    logic [3:0] exc;
    int g, r, dn;
    sz   = op_size(op);
    st   = (op == SB) || (op == SH) || (op == SW);
    sgn  = (op == LB) || (op == LH);
    mis  = (sz == 2 && addr[0]) || (sz == 4 && addr[1:0] != 2'b00);
    acc  = (sz > 0) && !mis;
    wa   = 5'($urandom);
    rwe  = 1'($urandom);
    rwd  = $urandom;
    base = addr - (addr % NL);
    ebe  = NL'(((1 << sz) - 1) << (addr % NL));
    edat = '0;
    for (int i = 0; i < NL; i++)
      if (sz > 0) edat[8*i +: 8] = data[8*(i % sz) +: 8];
    v = 0;
    for (int i = 0; i < sz; i++) v = v | (64'(rd(addr + i)) << (8 * i));
    if (sgn && v[8*sz-1]) v = v | ~((64'd1 << (8 * sz)) - 1);
    eres = v[31:0];
    exc  = 4'd0;
    if (mis) exc = st ? 4'd6 : 4'd4;
    else if (acc && (err || tmo)) exc = st ? 4'd7 : 4'd5;

    @(negedge clk_i);
    valid_i = 1'b1; mem_op_i = op; mem_addr_i = addr; mem_data_i = data;
    reg_waddr_i = wa; reg_we_i = rwe; reg_wdata_i = rwd;
    ram_gnt_i = 1'b0; ram_rvalid_i = 1'b0; ram_err_i = 1'b0;
    #1;
    check("stall_acc", stall_o, acc);
    check("req_acc", ram_req_o, 0);
    if (acc) begin
      g  = 1 + gdly;
      r  = g + rdly;
      dn = tmo ? TMO : r;
      for (int c = 1; c <= dn; c++) begin
        @(negedge clk_i);
        ram_gnt_i    = (c == g);
        ram_rvalid_i = !tmo && (c == r);
        ram_err_i    = ram_rvalid_i && err;
        for (int i = 0; i < NL; i++)
          bus[8*i +: 8] = ram_rvalid_i ? rd(base + i) : 8'($urandom);
        ram_rdata_i = bus;
        #1;
        check("req", ram_req_o, c <= g);
        check("stall", stall_o, c < dn);
        if (c == 1) begin
          check("ram_addr", ram_addr_o, base);
          check("ram_be", ram_be_o, ebe);
          check("ram_we", ram_we_o, st);
          if (st) check("ram_data", ram_data_o, edat);
        end
      end
      if (st && !tmo && !err)
        for (int i = 0; i < NL; i++)
          if (ebe[i]) mem[base + i] = edat[8*i +: 8];
    end
    @(negedge clk_i);
    valid_i = 1'b0; ram_gnt_i = 1'b0; ram_err_i = 1'b0;
    ram_rvalid_i = acc && tmo;
    #1;
    check("valid", valid_o, 1);
    check("req_done", ram_req_o, 0);
    check("exc_valid", exc_valid_o, exc != 0);
    check("exc_cause", exc_cause_o, exc);
    check("reg_we", reg_we_o, (exc != 0) ? 1'b0 : rwe);
    check("reg_waddr", reg_waddr_o, wa);
    if (exc == 0) check("reg_wdata", reg_wdata_o, (sz > 0 && !st) ? eres : rwd);
    @(negedge clk_i);
    ram_rvalid_i = 1'b0;
    #1;
    check("valid_pulse", valid_o, 0);
    check("stall_idle", stall_o, 0);
  endtask

  initial begin
    logic [3:0] op;
    rst_i = 1'b1; valid_i = 1'b0; reg_waddr_i = '0; reg_we_i = 1'b0;
    reg_wdata_i = '0; mem_addr_i = '0; mem_data_i = '0; mem_op_i = '0;
    ram_gnt_i = 1'b0; ram_rvalid_i = 1'b0; ram_rdata_i = '0; ram_err_i = 1'b0;
    mem[32'h1005] = 8'h80;
    mem[32'h4000] = 8'h0D;
    mem[32'h4001] = 8'hF0;
    repeat (2) @(negedge clk_i);
    #1;
    check_zero("reset");
    rst_i = 1'b0;

    do_op(LB,  32'h1005, 32'h0,         0, 1, 1'b0, 1'b0);
    do_op(SH,  32'h2002, 32'h0000ABCD,  0, 0, 1'b0, 1'b0);
    do_op(LW,  32'h3001, 32'h0,         0, 0, 1'b0, 1'b0);
    do_op(SH,  32'h3003, 32'h1234,      0, 0, 1'b0, 1'b0);
    do_op(LHU, 32'h4000, 32'h0,         3, 2, 1'b0, 1'b0);
    do_op(LH,  32'h4000, 32'h0,         1, 1, 1'b0, 1'b0);
    do_op(LB,  32'h1005, 32'h0,         1, 0, 1'b0, 1'b1);
    do_op(SW,  32'h2004, 32'h11223344,  0, 1, 1'b1, 1'b0);
    do_op(LW,  32'h2004, 32'h0,         0, 1, 1'b1, 1'b0);
    do_op(4'h0, 32'h0,   32'h0,         0, 0, 1'b0, 1'b0);
    do_op(4'hC, 32'h7,   32'h0,         0, 0, 1'b0, 1'b0);

    @(negedge clk_i);
    valid_i = 1'b1; mem_op_i = LW; mem_addr_i = 32'h1000;
    #1;
    @(negedge clk_i);
    ram_gnt_i = 1'b1;
    #1;
    check("rst_req", ram_req_o, 1);
    @(negedge clk_i);
    ram_gnt_i = 1'b0; rst_i = 1'b1;
    #1;
    check("rst_wait_stall", stall_o, 1);
    @(negedge clk_i);
    rst_i = 1'b0; valid_i = 1'b0; ram_rvalid_i = 1'b1; ram_rdata_i = '1;
    #1;
    check_zero("rst_mid");
    @(negedge clk_i);
    ram_rvalid_i = 1'b0;
    #1;
    check("rst_stale", valid_o, 0);
    do_op(SW, 32'h5000, 32'hDEADBEEF, 0, 1, 1'b0, 1'b0);
    do_op(LW, 32'h5000, 32'h0,        2, 0, 1'b0, 1'b0);

    for (int k = 0; k < 200; k++) begin
      op = 4'($urandom_range(0, 10));
      do_op(op, 32'h1000 + $urandom_range(0, 63), $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
